tff_seq: RTL and testbench



---
 rtl/tff_seq_if.sv | 23 ++
 rtl/tff_seq.sv | 188 ++++++++++++++++++
 tb/tb_tff_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tff_seq_if.sv
// Command/response bundle between the register interface (master) and the tff_seq sequencer (slave).
interface tff_seq_if #(
    parameter int LEN_W = 8,
    parameter int CW    = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             rsp_valid;
    logic [LEN_W-1:0] rsp_len;
    logic [CW-1:0]    rsp_carries;

    modport master (
        output cmd_valid, cmd_op, cmd_len,
        input  cmd_ready, rsp_valid, rsp_len, rsp_carries
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len,
        output cmd_ready, rsp_valid, rsp_len, rsp_carries
    );
endinterface

// File: rtl/tff_seq.sv
// Sequencer driving WE/RE/rstb of one tff delay-line cell, measuring replayed pulses and carry events.
// Optional TFF_SEQ_SHADOW_EN adds a shadow write accumulator and the shadow_err consistency flag.
module tff_seq #(
    parameter int RING_SEGS = 59,
    parameter int LEN_W     = 8,
    parameter int CW        = 4
) (
    input  logic      clk,
    input  logic      rst,
    tff_seq_if.slave  cmd,
    output logic      tff_we,
    output logic      tff_re,
    output logic      tff_rstb,
    input  logic      tff_out,
    input  logic      tff_carry,
    output logic      busy
`ifdef TFF_SEQ_SHADOW_EN
    ,
    output logic      shadow_err
`endif
);

    typedef enum logic [2:0] {IDLE, WRITE, WGAP, READ, CLEAR} state_t;

    localparam logic [LEN_W-1:0] RING_LEN = LEN_W'(RING_SEGS);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = '1;
    localparam logic [CW-1:0]    CW_ONE   = CW'(1);
    localparam logic [CW-1:0]    CW_MAX   = '1;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CW-1:0]    carries_q, carries_d;
    logic             init_q;
    logic             ready_q;
    logic             rsp_valid_q;
    logic             carry_s1, carry_s2;
    logic             carry_edge;
    logic             handshake;
    logic             we_d, re_d, rstb_d, ready_d, busy_d, rsp_valid_d;

    assign handshake       = cmd.cmd_valid && ready_q;
    assign carry_edge      = carry_s1 && !carry_s2;
    assign cmd.cmd_ready   = ready_q;
    assign cmd.rsp_valid   = rsp_valid_q;
    assign cmd.rsp_len     = len_q;
    assign cmd.rsp_carries = carries_q;

    // init_q forces one CLEAR pass after every reset so the cell starts empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (init_q) begin
                    state_d = CLEAR;
                end else if (handshake) begin
                    if (cmd.cmd_op) begin
                        state_d = READ;
                        cnt_d   = RING_LEN;
                    end else if (cmd.cmd_len == '0) begin
                        state_d = WGAP;
                    end else begin
                        state_d = WRITE;
                        cnt_d   = cmd.cmd_len;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_q - LEN_ONE;
                if (cnt_q == LEN_ONE) state_d = WGAP;
            end
            WGAP:  state_d = IDLE;
            READ: begin
                cnt_d = cnt_q - LEN_ONE;
                if (cnt_q == LEN_ONE) state_d = CLEAR;
            end
            CLEAR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins are decoded from the next state and registered, so they follow the state by one edge cleanly.
    always_comb begin
        we_d        = (state_d == WRITE);
        re_d        = (state_d == READ);
        rstb_d      = (state_d != CLEAR);
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == CLEAR) && (state_q == READ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tff_we      <= 1'b0;
            tff_re      <= 1'b0;
            tff_rstb    <= 1'b0;
            ready_q     <= 1'b0;
            busy        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            tff_we      <= we_d;
            tff_re      <= re_d;
            tff_rstb    <= rstb_d;
            ready_q     <= ready_d;
            busy        <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        len_d = len_q;
        if (handshake && cmd.cmd_op) begin
            len_d = '0;
        end else if (state_q == READ && tff_out && len_q != LEN_MAX) begin
            len_d = len_q + LEN_ONE;
        end
    end

    // Carry edges seen during CLEAR are dropped; the counter restarts from zero.
    always_comb begin
        carries_d = carries_q;
        if (state_q == CLEAR) begin
            carries_d = '0;
        end else if (carry_edge && carries_q != CW_MAX) begin
            carries_d = carries_q + CW_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            carries_q <= '0;
            carry_s1  <= 1'b0;
            carry_s2  <= 1'b0;
        end else begin
            len_q     <= len_d;
            carries_q <= carries_d;
            carry_s1  <= tff_carry;
            carry_s2  <= carry_s1;
        end
    end

`ifdef TFF_SEQ_SHADOW_EN
    logic [LEN_W-1:0] shadow_acc;
    logic [CW-1:0]    shadow_wraps;

    // Mirrors the cell position by counting WE cycles, wrapping at the ring length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_acc   <= '0;
            shadow_wraps <= '0;
        end else if (state_q == CLEAR) begin
            shadow_acc   <= '0;
            shadow_wraps <= '0;
        end else if (state_q == WRITE) begin
            if (shadow_acc == RING_LEN - LEN_ONE) begin
                shadow_acc <= '0;
                if (shadow_wraps != CW_MAX) shadow_wraps <= shadow_wraps + CW_ONE;
            end else begin
                shadow_acc <= shadow_acc + LEN_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_err <= 1'b0;
        end else if (rsp_valid_d) begin
            shadow_err <= (len_d != shadow_acc) || (carries_d != shadow_wraps);
        end
    end
`endif

endmodule

// File: tb/tb_tff_seq.sv
// Scoreboard bench for tff_seq with a behavioural tff cell; define TFF_SEQ_SHADOW_EN to also check shadow_err.
module tb_tff_seq;
    localparam int RING  = 59;
    localparam int LEN_W = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        int len;
        int carries;
    } rsp_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic tff_out   = 1'b0;
    logic tff_carry = 1'b0;
    logic tff_we, tff_re, tff_rstb, busy;
`ifdef TFF_SEQ_SHADOW_EN
    logic shadow_err;
`endif

    int   compared   = 0;
    int   mismatched = 0;
    int   exp_acc    = 0;
    int   exp_wraps  = 0;
    rsp_t rsp_q[$];
    int   we_q[$];
    int   cell_v     = 0;
    int   ridx       = 0;
    int   we_run     = 0;
    int   re_run     = 0;

    tff_seq_if #(.LEN_W(LEN_W), .CW(CW)) cmd ();

    tff_seq #(.RING_SEGS(RING), .LEN_W(LEN_W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .tff_we    (tff_we),
        .tff_re    (tff_re),
        .tff_rstb  (tff_rstb),
        .tff_out   (tff_out),
        .tff_carry (tff_carry),
        .busy      (busy)
`ifdef TFF_SEQ_SHADOW_EN
        ,
        .shadow_err(shadow_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural cell: WE cycles advance a position around the ring, RE replays it, rstb empties it.
    always @(negedge clk) begin
        if (!tff_rstb) begin
            cell_v    = 0;
            tff_carry = 1'b0;
        end else if (tff_we) begin
            cell_v++;
            if (cell_v == RING) begin
                cell_v    = 0;
                tff_carry = 1'b1;
            end else begin
                tff_carry = 1'b0;
            end
        end else begin
            tff_carry = 1'b0;
        end
        tff_out = tff_re && (ridx < cell_v);
        ridx    = tff_re ? ridx + 1 : 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("pin_rules",
                        int'((tff_we && tff_re) || (!tff_rstb && (tff_we || tff_re)) || (busy == cmd.cmd_ready)), 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            we_run = 0;
            re_run = 0;
        end else begin
            if (tff_we) begin
                we_run++;
            end else if (we_run > 0) begin
                if (we_q.size() == 0) checkOutput("we_unexpected", we_run, 0);
                else checkOutput("we_width", we_run, we_q.pop_front());
                we_run = 0;
            end
            if (tff_re) begin
                re_run++;
            end else if (re_run > 0) begin
                checkOutput("re_width", re_run, RING);
                re_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (!rst && cmd.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checkOutput("rsp_unexpected", 1, 0);
            end else begin
                e = rsp_q.pop_front();
                checkOutput("rsp_len", int'(cmd.rsp_len), e.len);
                checkOutput("rsp_carries", int'(cmd.rsp_carries), e.carries);
`ifdef TFF_SEQ_SHADOW_EN
                checkOutput("shadow_err", int'(shadow_err), 0);
`endif
            end
        end
    end

    // Issues one command at a negedge and records what the cell should hold afterwards.
    task automatic doHandshake(input bit op, input int len, output bit ok);
        int   w = 0;
        rsp_t e;
        while (!cmd.cmd_ready && w < 600) begin
            @(negedge clk);
            w++;
        end
        ok = cmd.cmd_ready;
        if (!ok) begin
            checkOutput("ready_wait", 0, 1);
            return;
        end
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_len   = LEN_W'(len);
        if (op) begin
            e.len     = exp_acc;
            e.carries = (exp_wraps > CMAX) ? CMAX : exp_wraps;
            rsp_q.push_back(e);
            exp_acc   = 0;
            exp_wraps = 0;
        end else begin
            if (len > 0) we_q.push_back(len);
            exp_acc   += len;
            exp_wraps += exp_acc / RING;
            exp_acc    = exp_acc % RING;
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit op, input int len, input bit hold);
        bit ok;
        int k;
        doHandshake(op, len, ok);
        if (!ok) return;
        k = 1;
        if (!hold) cmd.cmd_valid = 1'b0;
        while (!cmd.cmd_ready && k < 600) begin
            if (hold) begin
                cmd.cmd_len = LEN_W'($urandom_range(1, 255));
                cmd.cmd_op  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            k++;
        end
        cmd.cmd_valid = 1'b0;
        checkOutput(op ? "read_occupancy" : "write_occupancy", k, op ? RING + 2 : len + 2);
    endtask

    task automatic checkPostResetClear();
        @(negedge clk);
        checkOutput("clr_rstb", int'(tff_rstb), 0);
        checkOutput("clr_busy", int'(busy), 1);
        checkOutput("clr_rsp_valid", int'(cmd.rsp_valid), 0);
        @(negedge clk);
        checkOutput("idle_rstb", int'(tff_rstb), 1);
        checkOutput("idle_ready", int'(cmd.cmd_ready), 1);
        checkOutput("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 1'b0;
        cmd.cmd_len   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_we", int'(tff_we), 0);
        checkOutput("rst_re", int'(tff_re), 0);
        checkOutput("rst_rstb", int'(tff_rstb), 0);
        checkOutput("rst_ready", int'(cmd.cmd_ready), 0);
        checkOutput("rst_rsp_valid", int'(cmd.rsp_valid), 0);
        checkOutput("rst_rsp_len", int'(cmd.rsp_len), 0);
        checkOutput("rst_rsp_carries", int'(cmd.rsp_carries), 0);
        checkOutput("rst_busy", int'(busy), 0);
        #1 rst = 1'b0;
        checkPostResetClear();

        $display("[TB] read of empty cell");
        applyStimulus(1'b1, 0, 1'b0);

        $display("[TB] write 8, write 51, read");
        applyStimulus(1'b0, 8, 1'b0);
        applyStimulus(1'b0, 51, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);

        $display("[TB] zero-length write and held cmd_valid");
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 10, 1'b1);
        applyStimulus(1'b1, 0, 1'b0);

        $display("[TB] reset during read");
        applyStimulus(1'b0, 5, 1'b0);
        doHandshake(1'b1, 0, ok);
        cmd.cmd_valid = 1'b0;
        if (ok) begin
            repeat (19) @(negedge clk);
            #1 rst = 1'b1;
            #1 checkOutput("re_abort", int'(tff_re), 0);
            void'(rsp_q.pop_back());
            exp_acc   = 0;
            exp_wraps = 0;
            repeat (2) @(negedge clk);
            #1 rst = 1'b0;
            checkPostResetClear();
        end
        applyStimulus(1'b1, 0, 1'b0);

        $display("[TB] carry saturation");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 255, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);

        $display("[TB] random commands");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 0, 1'b0);
            else if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, int'($urandom_range(0, 3)), 1'b0);
            else applyStimulus(1'b0, int'($urandom_range(0, 255)), 1'b0);
        end
        applyStimulus(1'b1, 0, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("rsp_leftover", rsp_q.size(), 0);
        checkOutput("we_leftover", we_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
